or1200_wb_dual_arb: RTL

//  Shares one Wishbone slave port (unified memory/bus bridge) between two OR1200 masters:

---
 rtl/or1200_wb_dual_arb.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/or1200_wb_dual_arb.sv
// Round-robin Wishbone arbiter sharing one slave between OR1200 iwb (m0) and dwb (m1); grant takes 1 cycle,
// held for the whole master cycle; slave stalls pass straight through, hung strobes are ended with err by a watchdog.
module or1200_wb_dual_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic            m0_cab_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic            m1_cab_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic            s_cab_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  localparam int               CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit               WD_EN   = (TIMEOUT > 0);
  localparam logic [CW-1:0]    CNT_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stb_raw, resp, fire, g0, g1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_gnt_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: if (!m0_cyc_i) begin
        state_d    = m1_cyc_i ? GNT1 : IDLE;
        last_gnt_d = 1'b0;
      end
      GNT1: if (!m1_cyc_i) begin
        state_d    = m0_cyc_i ? GNT0 : IDLE;
        last_gnt_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign g0 = (state_q == GNT0);
  assign g1 = (state_q == GNT1);

  always_comb begin
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    s_we_o  = 1'b0;
    s_cab_o = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (g0) begin
      s_cyc_o = m0_cyc_i;
      stb_raw = m0_stb_i;
      s_we_o  = m0_we_i;
      s_cab_o = m0_cab_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (g1) begin
      s_cyc_o = m1_cyc_i;
      stb_raw = m1_stb_i;
      s_we_o  = m1_we_i;
      s_cab_o = m1_cab_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  // A real slave response in the expiry cycle takes priority over the watchdog.
  assign resp      = s_ack_i | s_err_i | s_rty_i;
  assign fire      = WD_EN && s_cyc_o && stb_raw && !resp && (cnt_q == CNT_MAX);
  assign s_stb_o   = stb_raw & ~fire;
  assign timeout_o = fire;

  always_comb begin
    cnt_d = '0;
    if (WD_EN && s_cyc_o && stb_raw && !resp && !fire && (state_d == state_q))
      cnt_d = cnt_q + 1'b1;
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = g0 & s_ack_i;
  assign m0_err_o = g0 & (s_err_i | fire);
  assign m0_rty_o = g0 & s_rty_i;
  assign m1_ack_o = g1 & s_ack_i;
  assign m1_err_o = g1 & (s_err_i | fire);
  assign m1_rty_o = g1 & s_rty_i;
  assign grant_o  = {g1, g0};

endmodule
